// File: rtl/lsu_pkg.sv
// Shared types and size helpers for the load/store unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      LSU_LB  = 3'd0,
      LSU_LBU = 3'd1,
      LSU_LH  = 3'd2,
      LSU_LHU = 3'd3,
      LSU_LW  = 3'd4
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   // Encodings 5-7 fall through to the word size.
   function automatic logic [2:0] lsu_bytes(input logic [2:0] num_byte);
      case (num_byte)
         LSU_LB, LSU_LBU: return 3'd1;
         LSU_LH, LSU_LHU: return 3'd2;
         default:         return 3'd4;
      endcase
   endfunction

   function automatic logic lsu_misaligned(input logic [1:0] off, input logic [2:0] num_byte);
      return ({2'b00, off} + {1'b0, lsu_bytes(num_byte)}) > 4'd4;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the LSU: store strobes and data positioning over two
// consecutive words, plus load extraction and sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [2:0]  num_byte_i,
   input  logic [31:0] wdata_i,
   input  logic [63:0] rdata64_i,
   output logic [7:0]  strb8_o,
   output logic [63:0] wdata64_o,
   output logic [31:0] load_o
);

   logic [4:0]  shamt;
   logic [7:0]  base_mask;
   logic [31:0] shifted;

   assign shamt = {off_i, 3'b000};

   // NOTE: every always_comb output gets a value before the case so no latch is inferred.
   always_comb begin
      base_mask = 8'h0F;
      case (lsu_bytes(num_byte_i))
         3'd1:    base_mask = 8'h01;
         3'd2:    base_mask = 8'h03;
         default: base_mask = 8'h0F;
      endcase
   end

   assign strb8_o   = base_mask << off_i;
   assign wdata64_o = {32'h0, wdata_i} << shamt;
   assign shifted   = 32'(rdata64_i >> shamt);

   always_comb begin
      load_o = shifted;
      case (num_byte_i)
         LSU_LB:  load_o = {{24{shifted[7]}}, shifted[7:0]};
         LSU_LBU: load_o = {24'h0, shifted[7:0]};
         LSU_LH:  load_o = {{16{shifted[15]}}, shifted[15:0]};
         LSU_LHU: load_o = {16'h0, shifted[15:0]};
         default: load_o = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one core request into one or two
// word-aligned bus beats and returns an extended load result.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  num_byte,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_strb,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  num_byte_q, num_byte_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        split;
   logic [31:0] word_addr;
   logic [7:0]  strb8;
   logic [63:0] wdata64;
   logic [63:0] rdata64;
   logic [31:0] load_ext;

   assign split     = lsu_misaligned(addr_q[1:0], num_byte_q);
   assign word_addr = {addr_q[31:2], 2'b00};

   // The final beat's data comes straight off the bus so rdata is ready in DONE.
   assign rdata64 = (state_q == ACC1) ? {bus_rdata, lo_q} : {hi_q, bus_rdata};

   lsu_align u_align (
      .off_i      (addr_q[1:0]),
      .num_byte_i (num_byte_q),
      .wdata_i    (wdata_q),
      .rdata64_i  (rdata64),
      .strb8_o    (strb8),
      .wdata64_o  (wdata64),
      .load_o     (load_ext)
   );

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      num_byte_d = num_byte_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      stall      = 1'b0;
      bus_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               stall      = 1'b1;
               we_d       = we;
               addr_d     = addr;
               wdata_d    = wdata;
               num_byte_d = num_byte;
               err_d      = 1'b0;
               if (!SPLIT_EN && lsu_misaligned(addr[1:0], num_byte)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = ACC0;
               end
            end
         end
         ACC0: begin
            stall     = 1'b1;
            bus_valid = 1'b1;
            if (bus_ready) begin
               lo_d = bus_rdata;
               if (split) begin
                  state_d = ACC1;
               end else begin
                  state_d = DONE;
                  if (!we_q) rdata_d = load_ext;
               end
            end
         end
         ACC1: begin
            stall     = 1'b1;
            bus_valid = 1'b1;
            if (bus_ready) begin
               hi_d    = bus_rdata;
               state_d = DONE;
               if (!we_q) rdata_d = load_ext;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         num_byte_q <= 3'd0;
         lo_q       <= 32'h0;
         hi_q       <= 32'h0;
         rdata_q    <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         num_byte_q <= num_byte_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Bus fields derive only from latched state, so they hold steady until ready.
   assign bus_addr  = (state_q == ACC1) ? word_addr + 32'd4 : word_addr;
   assign bus_we    = bus_valid & we_q;
   assign bus_wdata = (state_q == ACC1) ? wdata64[63:32] : wdata64[31:0];
   assign bus_strb  = !(bus_valid && we_q) ? 4'h0 :
                      (state_q == ACC1) ? strb8[7:4] : strb8[3:0];
   assign done      = (state_q == DONE);
   assign err       = done & err_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a bench-side byte model predicts every bus
// beat and completion; a slave process answers beats with optional wait states.
module tb_lsu_ctrl;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } comp_t;

   logic        clk, rst, req, req_ns, we;
   logic [31:0] addr, wdata;
   logic [2:0]  num_byte;
   logic        stall, done, err, bus_valid, bus_we, bus_ready;
   logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_strb;
   logic        ns_stall, ns_done, ns_err, ns_bus_valid, ns_bus_we, ns_bus_ready;
   logic [31:0] ns_rdata, ns_bus_addr, ns_bus_wdata;
   logic [3:0]  ns_bus_strb;

   int          total, bad, cyc, req_cyc, ready_wait;
   logic [31:0] cur_base, cur_lo, cur_hi, hold_rdata;
   beat_t       beats[$];
   comp_t       comps[$];

   lsu_ctrl #(.SPLIT_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .num_byte(num_byte), .stall(stall), .rdata(rdata), .done(done), .err(err),
      .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_ready(bus_ready),
      .bus_rdata(bus_rdata)
   );

   lsu_ctrl #(.SPLIT_EN(1'b0)) u_dut_ns (
      .clk(clk), .rst(rst), .req(req_ns), .we(we), .addr(addr), .wdata(wdata),
      .num_byte(num_byte), .stall(ns_stall), .rdata(ns_rdata), .done(ns_done),
      .err(ns_err), .bus_valid(ns_bus_valid), .bus_we(ns_bus_we),
      .bus_addr(ns_bus_addr), .bus_wdata(ns_bus_wdata), .bus_strb(ns_bus_strb),
      .bus_ready(ns_bus_ready), .bus_rdata(bus_rdata)
   );

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Bus slave: raises ready after ready_wait low cycles and checks each beat.
   initial begin : p_slave
      int cnt;
      logic [95:0] snap, cur;
      beat_t b;
      cnt = 0;
      snap = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus_ready = 1'b0;
            cnt = 0;
         end else if (bus_valid) begin
            cur = {27'h0, bus_we, bus_addr, bus_wdata, bus_strb};
            if (cnt == 0) snap = cur;
            else check("bus_stable", cur, snap);
            bus_rdata = (bus_addr == cur_base) ? cur_lo : cur_hi;
            if (cnt >= ready_wait) begin
               bus_ready = 1'b1;
               cnt = 0;
               if (beats.size() == 0) begin
                  check("unexpected_beat", bus_addr, 32'hFFFF_FFFF);
               end else begin
                  b = beats.pop_front();
                  check("beat_addr", bus_addr, b.addr);
                  check("beat_we", bus_we, b.we);
                  check("beat_strb", bus_strb, b.strb);
                  check("beat_wdata", bus_wdata & lane_mask(b.strb), b.wdata & lane_mask(b.strb));
               end
            end else begin
               bus_ready = 1'b0;
               cnt++;
            end
         end else begin
            bus_ready = 1'b0;
            cnt = 0;
         end
      end
   end

   // Completion monitor.
   initial begin : p_done
      comp_t c;
      forever begin
         @(negedge clk);
         if (done) begin
            if (comps.size() == 0) begin
               check("spurious_done", done, 1'b0);
            end else begin
               c = comps.pop_front();
               check("rdata", rdata, c.rdata);
               check("err", err, c.err);
               check("latency", cyc - req_cyc, c.lat);
            end
         end
      end
   end

   task automatic expect_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] nb, input int wt, input logic [31:0] lo,
                                input logic [31:0] hi, output comp_t c);
      int sz, o;
      logic [7:0]  m8;
      logic [63:0] d64, r64;
      logic [31:0] v;
      beat_t b;
      sz  = (nb <= 3'd1) ? 1 : (nb <= 3'd3) ? 2 : 4;
      o   = int'(a[1:0]);
      m8  = '0;
      d64 = '0;
      v   = '0;
      r64 = {hi, lo};
      for (int i = 0; i < sz; i++) begin
         m8[o+i] = 1'b1;
         d64[8*(o+i) +: 8] = wd[8*i +: 8];
         v[8*i +: 8] = r64[8*(o+i) +: 8];
      end
      if (nb == 3'd0) v = {{24{v[7]}}, v[7:0]};
      else if (nb == 3'd2) v = {{16{v[15]}}, v[15:0]};
      b.addr  = {a[31:2], 2'b00};
      b.we    = w;
      b.strb  = w ? m8[3:0] : 4'h0;
      b.wdata = d64[31:0];
      beats.push_back(b);
      if (o + sz > 4) begin
         b.addr  = b.addr + 32'd4;
         b.strb  = w ? m8[7:4] : 4'h0;
         b.wdata = d64[63:32];
         beats.push_back(b);
      end
      if (!w) hold_rdata = v;
      c.rdata = hold_rdata;
      c.err   = 1'b0;
      c.lat   = (o + sz > 4) ? 3 + 2 * wt : 2 + wt;
      cur_base   = {a[31:2], 2'b00};
      cur_lo     = lo;
      cur_hi     = hi;
      ready_wait = wt;
   endtask

   task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] nb, input int wt, input logic [31:0] lo,
                            input logic [31:0] hi);
      comp_t c;
      bit seen;
      expect_access(w, a, wd, nb, wt, lo, hi, c);
      comps.push_back(c);
      @(negedge clk);
      we = w; addr = a; wdata = wd; num_byte = nb; req = 1'b1;
      req_cyc = cyc;
      #1 check("stall_req", stall, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            check("stall_done", stall, 1'b0);
         end else begin
            check("stall_busy", stall, 1'b1);
         end
      end
      if (!seen) check("done_timeout", seen, 1'b1);
      req = 1'b0;
   endtask

   initial begin
      comp_t c;
      bit    found;
      total = 0; bad = 0; req_cyc = 0; ready_wait = 0;
      cur_base = '0; cur_lo = '0; cur_hi = '0; hold_rdata = '0;
      rst = 1'b1; req = 1'b0; req_ns = 1'b0; we = 1'b0;
      addr = '0; wdata = '0; num_byte = 3'd4;
      bus_ready = 1'b0; bus_rdata = '0; ns_bus_ready = 1'b0;

      #1;
      check("rst_stall", stall, 1'b0);
      check("rst_bus_valid", bus_valid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      repeat (3) begin
         @(negedge clk);
         check("idle_bus_valid", bus_valid, 1'b0);
         check("idle_stall", stall, 1'b0);
      end

      do_access(1'b0, 32'h0000_0100, 32'h0, 3'd4, 0, 32'hDEAD_BEEF, 32'h0);
      do_access(1'b0, 32'h0000_0103, 32'h0, 3'd0, 0, 32'h8012_3456, 32'h0);
      do_access(1'b0, 32'h0000_0103, 32'h0, 3'd1, 0, 32'h8012_3456, 32'h0);
      do_access(1'b1, 32'h0000_0102, 32'h1122_3344, 3'd4, 0, 32'h0, 32'h0);
      do_access(1'b0, 32'h0000_0103, 32'h0, 3'd2, 2, 32'hAB00_0000, 32'h0000_00CD);
      do_access(1'b0, 32'h0000_0202, 32'h0, 3'd3, 1, 32'h8765_4321, 32'h0);
      do_access(1'b1, 32'h0000_0301, 32'hCAFE_F00D, 3'd0, 1, 32'h0, 32'h0);
      do_access(1'b0, 32'hFFFF_FFFD, 32'h0, 3'd4, 1, 32'h1234_5678, 32'h9ABC_DEF0);

      // Misaligned word without split support: error after one stall cycle.
      @(negedge clk);
      we = 1'b0; addr = 32'h0000_0101; num_byte = 3'd4; req_ns = 1'b1;
      #1;
      check("ns_stall_req", ns_stall, 1'b1);
      check("ns_bus_valid0", ns_bus_valid, 1'b0);
      @(negedge clk);
      check("ns_done", ns_done, 1'b1);
      check("ns_err", ns_err, 1'b1);
      check("ns_bus_valid1", ns_bus_valid, 1'b0);
      check("ns_stall_done", ns_stall, 1'b0);
      req_ns = 1'b0;
      @(negedge clk);
      check("ns_done_clear", ns_done, 1'b0);
      check("ns_err_clear", ns_err, 1'b0);

      // Reset while the second beat of a split load is waiting.
      expect_access(1'b0, 32'h0000_0103, 32'h0, 3'd2, 5, 32'hAB00_0000, 32'h0000_00CD, c);
      @(negedge clk);
      we = 1'b0; addr = 32'h0000_0103; num_byte = 3'd2; req = 1'b1;
      req_cyc = cyc;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (bus_valid && bus_addr == 32'h0000_0104) found = 1'b1;
      end
      check("acc1_reached", found, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("midrst_bus_valid", bus_valid, 1'b0);
      check("midrst_done", done, 1'b0);
      req = 1'b0;
      #1;
      check("midrst_stall", stall, 1'b0);
      check("midrst_rdata", rdata, 32'h0);
      beats.delete();
      hold_rdata = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_access(1'b0, 32'h0000_0100, 32'h0, 3'd4, 0, 32'h0BAD_CAFE, 32'h0);

      for (int n = 0; n < 16; n++) begin
         do_access(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 2)), $urandom, $urandom);
      end

      repeat (3) @(negedge clk);
      check("beats_drained", beats.size(), 0);
      check("comps_drained", comps.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: SPLIT_EN, 1, 1 = misaligned access split into two bus beats; 0 = misaligned access completes with err and no bus beat.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  1  core memory request (mem_read | mem_wren); held stable while stall=1.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 addr  in  32  byte address.
REQ-007 wdata  in  32  store data, LSB-justified.
REQ-008 num_byte  in  3  0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw; 5-7 treated as lw.
REQ-009 stall  out  1  freeze core PC/regfile.
REQ-010 rdata  out  32  extended load result, valid when done=1.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  misalignment error, valid with done.
REQ-013 bus_valid  out  1  bus request.
REQ-014 bus_we  out  1  bus write.
REQ-015 bus_addr  out  32  word-aligned address (bits[1:0]=0).
REQ-016 bus_wdata  out  32  lane-positioned write data.
REQ-017 bus_strb  out  4  byte-lane write enables; 0 on reads.
REQ-018 bus_ready  in  1  slave accepts the beat.
REQ-019 bus_rdata  in  32  read data, valid in the bus_valid&bus_ready cycle.

Function
REQ-020 FSM states IDLE, ACC0, ACC1, DONE.
REQ-021 IDLE: req=1 -> ACC0 (or DONE with err if misaligned and SPLIT_EN=0); latch we, addr, wdata, num_byte.
REQ-022 stall = (IDLE & req) | ACC0 | ACC1; stall=0 in DONE.
REQ-023 Size: 1 byte for lb/lbu, 2 for lh/lhu, 4 for lw; off = addr[1:0].
REQ-024 Misaligned: off+size > 4; aligned accesses use ACC0 only.
REQ-025 ACC0 beat: bus_addr = {addr[31:2],2'b00}; ACC1 beat: that address + 4, wrapping modulo 2^32.
REQ-026 Store: 8-bit mask ((1<<size)-1)<<off and 64-bit data wdata<<(8*off); ACC0 uses the low halves, ACC1 the high halves.
REQ-027 bus_valid, bus_we, bus_addr, bus_wdata and bus_strb stay stable from assertion until the bus_ready cycle.
REQ-028 ACC0 handshake -> ACC1 if misaligned, else DONE; ACC1 handshake -> DONE; no handshake -> hold state.
REQ-029 Load: capture bus_rdata at each handshake as lo (ACC0) and hi (ACC1); result = {hi,lo}>>(8*off), truncated to size.
REQ-030 Extension: sign-extend for lb/lh; zero-extend for lbu/lhu.
REQ-031 DONE: done=1 for one cycle; rdata registered and valid; err as decided; -> IDLE unconditionally.
REQ-032 rdata holds its value until the next DONE; stores leave rdata unchanged.
REQ-033 Latency with bus_ready=1: aligned access 2 stall cycles, split access 3 stall cycles, SPLIT_EN=0 error 1 stall cycle.
REQ-034 req=0 in IDLE: no bus activity, stall=0.

Reset
REQ-035 rst=1 forces, without waiting for clk: state IDLE; bus_valid, done, err and stall 0; rdata and captured lo/hi 0.
REQ-036 Reset mid-beat drops bus_valid immediately and abandons the access; no done pulse.

Structure
REQ-037 Package lsu_pkg holds the num_byte encoding enum (LSU_LB..LSU_LW) and the FSM state enum.
REQ-038 Sub-module lsu_align (combinational) computes strobe mask, data shift and load extension; lsu_ctrl holds the FSM and registers.

Verification
REQ-039 lw addr 0x100, bus_ready=1, bus_rdata 0xDEADBEEF -> one beat at 0x100, done 2 cycles after req, rdata 0xDEADBEEF.
REQ-040 lb addr 0x103, bus_rdata 0x80xxxxxx -> rdata 0xFFFFFF80; with lbu -> 0x00000080.
REQ-041 sw addr 0x102, wdata 0x11223344 -> beat 1 at 0x100: strb 1100, wdata[31:16]=0x3344; beat 2 at 0x104: strb 0011, wdata[15:0]=0x1122; done 3 cycles after req.
REQ-042 lh addr 0x103, first read 0xAB000000 and second 0x000000CD, bus_ready low 2 cycles per beat -> stall held, bus fields stable, rdata 0xFFFFCDAB.
REQ-043 SPLIT_EN=0, lw addr 0x101 -> no bus_valid, done=1 and err=1 one cycle after req.
REQ-044 rst asserted during an ACC1 wait -> bus_valid 0 same cycle, no done pulse; next request proceeds normally.
